// File: rtl/sipo_pkt_buf.sv
// Serial-to-parallel packet deserializer with a word FIFO on the output side.
// Partial words at end-of-packet carry their bit count; on overflow the rest of the packet is dropped.
//
//   state | meaning
//   IDLE  | no packet in progress
//   RECV  | packet in progress, bits being assembled
//   DROP  | discarding the rest of a packet after a failed push
module sipo_pkt_buf #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int MSB_FIRST  = 0,
   localparam int NBW = $clog2(DATA_WIDTH + 1),
   localparam int LW  = $clog2(FIFO_DEPTH + 1),
   localparam int PW  = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_data_in,
   input  logic                  s_data_in_val,
   input  logic                  s_eop,
   input  logic                  sipo_cancel,
   output logic [DATA_WIDTH-1:0] p_data_out,
   output logic                  p_data_out_val,
   input  logic                  p_data_out_rdy,
   output logic                  p_data_out_last,
   output logic [NBW-1:0]        p_data_out_nbits,
   output logic [LW-1:0]         fifo_level,
   output logic                  overflow
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t                state, state_nxt;
   logic [NBW-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0] word;
   logic [DATA_WIDTH-1:0] word_nxt;
   logic [NBW-1:0]        bit_pos;
   logic                  take_bit, at_top, push_req, has_room, push_ok, push_fail, pop;

   logic [DATA_WIDTH-1:0] mem_data  [FIFO_DEPTH];
   logic                  mem_last  [FIFO_DEPTH];
   logic [NBW-1:0]        mem_nbits [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;

   assign pop       = p_data_out_val & p_data_out_rdy;
   assign take_bit  = s_data_in_val && (state != DROP);
   assign at_top    = (bit_cnt == NBW'(DATA_WIDTH - 1));
   assign push_req  = take_bit && (at_top || s_eop);
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign has_room  = (fifo_level != LW'(FIFO_DEPTH)) || pop;
   assign push_ok   = push_req && has_room;
   assign push_fail = push_req && !has_room;
   assign bit_pos   = (MSB_FIRST != 0) ? (NBW'(DATA_WIDTH - 1) - bit_cnt) : bit_cnt;
   assign word_nxt  = word | (DATA_WIDTH'(s_data_in) << bit_pos);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (take_bit && !s_eop) state_nxt = RECV;
         RECV: begin
            if (take_bit) begin
               if (s_eop)          state_nxt = IDLE;
               else if (push_fail) state_nxt = DROP;
            end
         end
         DROP:    if (s_data_in_val && s_eop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (sipo_cancel) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         word    <= '0;
      end else if (sipo_cancel) begin
         bit_cnt <= '0;
         word    <= '0;
      end else if (take_bit) begin
         if (push_req) begin
            bit_cnt <= '0;
            word    <= '0;
         end else begin
            bit_cnt <= bit_cnt + NBW'(1);
            word    <= word_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i]  <= '0;
            mem_last[i]  <= 1'b0;
            mem_nbits[i] <= '0;
         end
      end else if (sipo_cancel) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_data[wr_ptr]  <= word_nxt;
            mem_last[wr_ptr]  <= s_eop;
            mem_nbits[wr_ptr] <= bit_cnt + NBW'(1);
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop)      fifo_level <= fifo_level + LW'(1);
         else if (!push_ok && pop) fifo_level <= fifo_level - LW'(1);
         if (push_fail) overflow <= 1'b1;
      end
   end

   assign p_data_out       = mem_data[rd_ptr];
   assign p_data_out_last  = mem_last[rd_ptr];
   assign p_data_out_nbits = mem_nbits[rd_ptr];
   assign p_data_out_val   = (fifo_level != '0);

endmodule

// File: tb/tb_sipo_pkt_buf.sv
// Directed bench for sipo_pkt_buf: stimulus pushes expected words into queues,
// negedge monitors pop and compare whenever a DUT hands a word over.
module tb_sipo_pkt_buf;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] nbits;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic drv_bit = 1'b0, drv_val = 1'b0, drv_eop = 1'b0, cancel = 1'b0;
   logic sel_b = 1'b0;
   logic rdy = 1'b1;
   logic b_rdy = 1'b1;

   logic [7:0] a_data, b_data;
   logic       a_val, a_last, b_val, b_last;
   logic [3:0] a_nbits, b_nbits;
   logic [2:0] a_level, b_level;
   logic       a_ovf, b_ovf;

   exp_t q_a[$];
   exp_t q_b[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sipo_pkt_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_a (
      .clk(clk), .rst(rst), .s_data_in(drv_bit), .s_data_in_val(drv_val & ~sel_b),
      .s_eop(drv_eop), .sipo_cancel(cancel), .p_data_out(a_data), .p_data_out_val(a_val),
      .p_data_out_rdy(rdy), .p_data_out_last(a_last), .p_data_out_nbits(a_nbits),
      .fifo_level(a_level), .overflow(a_ovf));

   sipo_pkt_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_b (
      .clk(clk), .rst(rst), .s_data_in(drv_bit), .s_data_in_val(drv_val & sel_b),
      .s_eop(drv_eop), .sipo_cancel(cancel), .p_data_out(b_data), .p_data_out_val(b_val),
      .p_data_out_rdy(b_rdy), .p_data_out_last(b_last), .p_data_out_nbits(b_nbits),
      .fifo_level(b_level), .overflow(b_ovf));

   task automatic mon_check(string name, exp_t e, logic [7:0] d, logic [3:0] n, logic l);
      total++;
      if (d !== e.data || n !== e.nbits || l !== e.last) begin
         bad++;
         $display("FAIL %s: got data=%h nbits=%0d last=%b, want data=%h nbits=%0d last=%b",
                  name, d, n, l, e.data, e.nbits, e.last);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && a_val && rdy) begin
         if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL mon_a: unexpected word data=%h nbits=%0d last=%b", a_data, a_nbits, a_last);
         end else begin
            mon_check("mon_a", q_a.pop_front(), a_data, a_nbits, a_last);
         end
      end
      if (!rst && b_val && b_rdy) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL mon_b: unexpected word data=%h", b_data);
         end else begin
            mon_check("mon_b", q_b.pop_front(), b_data, b_nbits, b_last);
         end
      end
   end

   task automatic chk(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic send_bit(logic b, logic e);
      drv_bit = b; drv_val = 1'b1; drv_eop = e;
      @(posedge clk); #1;
      drv_val = 1'b0; drv_eop = 1'b0;
   endtask

   task automatic send_word(logic [7:0] w, int n, logic eop_last);
      for (int i = 0; i < n; i++) send_bit(w[i], eop_last && (i == n - 1));
   endtask

   task automatic expect_a(logic [7:0] d, logic [3:0] n, logic l);
      exp_t e;
      e.data = d; e.nbits = n; e.last = l;
      q_a.push_back(e);
   endtask

   task automatic pulse_cancel();
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
   endtask

   task automatic drain(string name);
      int n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #1;
      chk({name, "_drained"}, q_a.size() + q_b.size(), 0);
   endtask

   initial begin
      #1;
      chk("rst_data", a_data, 0);
      chk("rst_val", a_val, 0);
      chk("rst_level_ovf", {a_level, a_ovf, a_last, a_nbits}, 0);
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // LSB-first word, output one cycle after the 8th bit
      expect_a(8'h4D, 4'd8, 1'b0);
      send_word(8'h4D, 7, 1'b0);
      @(negedge clk); chk("t1_val_before", a_val, 0);
      @(posedge clk); #1;
      send_bit(1'b0, 1'b0);
      @(negedge clk); chk("t1_val_after", a_val, 1);
      @(negedge clk); chk("t1_val_one_cycle", a_val, 0);
      @(posedge clk); #1;
      pulse_cancel();

      // full word followed by 3-bit tail ending the packet, then a 1-bit packet
      expect_a(8'h4D, 4'd8, 1'b0);
      expect_a(8'h07, 4'd3, 1'b1);
      send_word(8'h4D, 8, 1'b0);
      send_word(8'h07, 3, 1'b1);
      expect_a(8'h01, 4'd1, 1'b1);
      send_bit(1'b1, 1'b1);
      drain("t2");

      // stall of 3 cycles after bit 4 does not disturb assembly
      expect_a(8'h4D, 4'd8, 1'b1);
      send_word(8'h0D, 4, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      send_word(8'h04, 3, 1'b0);
      @(negedge clk); chk("t3_val_before", a_val, 0);
      @(posedge clk); #1;
      send_bit(1'b0, 1'b1);
      @(negedge clk); chk("t3_val_after", a_val, 1);
      drain("t3");

      // overflow: 5 words into a 4-deep FIFO with rdy low, eop mid 6th word
      rdy = 1'b0;
      expect_a(8'hA1, 4'd8, 1'b0);
      expect_a(8'hB2, 4'd8, 1'b0);
      expect_a(8'hC3, 4'd8, 1'b0);
      expect_a(8'hD4, 4'd8, 1'b0);
      send_word(8'hA1, 8, 1'b0);
      send_word(8'hB2, 8, 1'b0);
      send_word(8'hC3, 8, 1'b0);
      send_word(8'hD4, 8, 1'b0);
      chk("t4_ovf_before", a_ovf, 0);
      send_word(8'hE5, 8, 1'b0);
      chk("t4_level", a_level, 4);
      chk("t4_ovf", a_ovf, 1);
      send_word(8'h06, 3, 1'b1);
      chk("t4_level_drop", a_level, 4);
      rdy = 1'b1;
      expect_a(8'h5A, 4'd8, 1'b1);
      send_word(8'h5A, 8, 1'b1);
      drain("t4");
      chk("t4_ovf_sticky", a_ovf, 1);
      pulse_cancel();
      chk("t4_ovf_cleared", a_ovf, 0);

      // full FIFO: push and pop in the same cycle keeps level, no overflow
      rdy = 1'b0;
      expect_a(8'h11, 4'd8, 1'b0);
      expect_a(8'h22, 4'd8, 1'b0);
      expect_a(8'h33, 4'd8, 1'b0);
      expect_a(8'h44, 4'd8, 1'b0);
      expect_a(8'h55, 4'd8, 1'b1);
      send_word(8'h11, 8, 1'b0);
      send_word(8'h22, 8, 1'b0);
      send_word(8'h33, 8, 1'b0);
      send_word(8'h44, 8, 1'b0);
      send_word(8'h55, 7, 1'b0);
      chk("t5_full", a_level, 4);
      rdy = 1'b1;
      send_bit(1'b0, 1'b1);
      chk("t5_level_kept", a_level, 4);
      chk("t5_no_ovf", a_ovf, 0);
      drain("t5");

      // MSB-first instance
      sel_b = 1'b1;
      q_b.push_back(exp_t'{data: 8'hB2, nbits: 4'd8, last: 1'b0});
      send_word(8'h4D, 8, 1'b0);
      drain("t6");
      sel_b = 1'b0;

      // cancel at level 2, mid-word
      rdy = 1'b0;
      send_word(8'h0F, 8, 1'b0);
      send_word(8'hF0, 8, 1'b0);
      send_word(8'h05, 3, 1'b0);
      chk("t7_level_pre", a_level, 2);
      pulse_cancel();
      chk("t7_val", a_val, 0);
      chk("t7_level", a_level, 0);
      chk("t7_ovf", a_ovf, 0);
      rdy = 1'b1;
      expect_a(8'h4D, 4'd8, 1'b1);
      send_word(8'h4D, 8, 1'b1);
      drain("t7");

      // asynchronous reset between edges, mid-packet with a word held
      rdy = 1'b0;
      send_word(8'h3C, 8, 1'b0);
      send_word(8'h03, 3, 1'b0);
      chk("t8_held", a_data, 8'h3C);
      #2 rst = 1'b1;
      #1;
      chk("t8_data", a_data, 0);
      chk("t8_val", a_val, 0);
      chk("t8_last_nbits", {a_last, a_nbits}, 0);
      chk("t8_level", a_level, 0);
      @(negedge clk) rst = 1'b0;
      rdy = 1'b1;
      @(posedge clk); #1;
      expect_a(8'h4D, 4'd8, 1'b1);
      send_word(8'h4D, 8, 1'b1);
      drain("t8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
